// File: rtl/beep_pkg.sv
// Shared types and defaults for the beep scheduler.
// Holds the FSM state enum, pattern codes and default timings.
package beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_GAP  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        PAT_SHORT1 = 2'b00,
        PAT_LONG1  = 2'b01,
        PAT_SHORT2 = 2'b10,
        PAT_SHORT3 = 2'b11
    } pat_e;

    localparam int SHORT_T_DEF = 5;
    localparam int LONG_T_DEF  = 20;
    localparam int GAP_T_DEF   = 5;

    // Beeps still to play after the first one of a pattern.
    function automatic logic [1:0] extra_beeps(input pat_e p);
        logic [1:0] n;
        n = 2'd0;
        unique case (p)
            PAT_SHORT2: n = 2'd1;
            PAT_SHORT3: n = 2'd2;
            default:    n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among requesters.
// Ports: req (levels), last (index granted last), win (one-hot winner).
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic [NREQ-1:0] win
);

    int  j;
    logic found;

    // Search starts one past the last winner and wraps around.
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 1; i <= NREQ; i++) begin
            j = int'(last) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req[IDXW'(j)]) begin
                win[IDXW'(j)] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/beep_scheduler.sv
// Arbitrates beep requests and times short/long beep patterns.
// Ports: clk_bps, rst, req, pat, stop in; gnt, busy, buz_en, done out.
module beep_scheduler
    import beep_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int SHORT_T = SHORT_T_DEF,
    parameter int LONG_T  = LONG_T_DEF,
    parameter int GAP_T   = GAP_T_DEF
) (
    input  logic              clk_bps,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] pat,
    input  logic              stop,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              buz_en,
    output logic              done
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] SHORT_C = 8'(SHORT_T);
    localparam logic [7:0] LONG_C  = 8'(LONG_T);
    localparam logic [7:0] GAP_C   = 8'(GAP_T);
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);

    state_e          state_q, state_d;
    logic [7:0]      tick_q, tick_d;
    logic [1:0]      beeps_q, beeps_d;
    pat_e            pat_q, pat_d;
    logic [IDXW-1:0] last_q, last_d;
    logic [NREQ-1:0] gnt_d;
    logic            busy_d, buz_d, done_d;

    logic [NREQ-1:0] win;
    logic [IDXW-1:0] win_idx;
    logic [1:0]      win_pat;
    logic [7:0]      on_t, win_on_t;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .req  (req),
        .last (last_q),
        .win  (win)
    );

    always_comb begin
        win_idx = '0;
        win_pat = 2'b00;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_idx = IDXW'(i);
                win_pat = pat[2*i +: 2];
            end
        end
    end

    assign on_t     = (pat_q == PAT_LONG1) ? LONG_C : SHORT_C;
    assign win_on_t = (pat_e'(win_pat) == PAT_LONG1) ? LONG_C : SHORT_C;

    // State register; outputs are registered alongside the state.
    always_ff @(posedge clk_bps or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tick_q  <= 8'd0;
            beeps_q <= 2'd0;
            pat_q   <= PAT_SHORT1;
            last_q  <= LAST_RST;
            gnt     <= '0;
            busy    <= 1'b0;
            buz_en  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            beeps_q <= beeps_d;
            pat_q   <= pat_d;
            last_q  <= last_d;
            gnt     <= gnt_d;
            busy    <= busy_d;
            buz_en  <= buz_d;
            done    <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        beeps_d = beeps_q;
        pat_d   = pat_q;
        last_d  = last_q;
        gnt_d   = gnt;
        // Count down to 1 and hold there; never wraps.
        tick_d  = (tick_q > 8'd1) ? tick_q - 8'd1 : tick_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!stop && (|req)) begin
                    state_d = ST_ON;
                    gnt_d   = win;
                    last_d  = win_idx;
                    pat_d   = pat_e'(win_pat);
                    tick_d  = win_on_t;
                    beeps_d = extra_beeps(pat_e'(win_pat));
                end
            end
            ST_ON: begin
                if (tick_q <= 8'd1) begin
                    if (beeps_q != 2'd0) begin
                        state_d = ST_GAP;
                        tick_d  = GAP_C;
                        beeps_d = beeps_q - 2'd1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_GAP: begin
                if (tick_q <= 8'd1) begin
                    state_d = ST_ON;
                    tick_d  = on_t;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        // Abort wins over everything; last_q already names this requester.
        if (stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
        end
    end

    // Output decode from the next state, so outputs track state exactly.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        buz_d  = (state_d == ST_ON);
        done_d = (state_d == ST_DONE);
    end

endmodule

// File: tb/tb_beep_scheduler.sv
// Directed bench for beep_scheduler with a grant-order scoreboard.
// Checks timing, arbitration order, abort, reset and stop priority.
module tb_beep_scheduler;

    logic       clk_bps = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] pat;
    logic       stop;
    logic [3:0] gnt;
    logic       busy, buz_en, done;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];
    logic [3:0] prev_gnt = 4'b0;

    beep_scheduler dut (
        .clk_bps (clk_bps),
        .rst     (rst),
        .req     (req),
        .pat     (pat),
        .stop    (stop),
        .gnt     (gnt),
        .busy    (busy),
        .buz_en  (buz_en),
        .done    (done)
    );

    always #5 clk_bps = ~clk_bps;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_bps);
        #1;
    endtask

    // Expected pattern figures from pattern code.
    function automatic int n_beeps(input logic [1:0] c);
        return (c == 2'b10) ? 2 : (c == 2'b11) ? 3 : 1;
    endfunction
    function automatic int on_len(input logic [1:0] c);
        return (c == 2'b01) ? 20 : 5;
    endfunction
    function automatic int busy_len(input logic [1:0] c);
        return n_beeps(c) * on_len(c) + (n_beeps(c) - 1) * 5 + 1;
    endfunction

    // Scoreboard: every new grant must match the next queued one.
    always @(negedge clk_bps) begin
        if (gnt !== 4'b0 && prev_gnt === 4'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", {28'b0, gnt}, 32'h0);
            end else begin
                chk("grant_order", {28'b0, gnt}, {28'b0, exp_q.pop_front()});
            end
        end
        prev_gnt = gnt;
    end

    // Follows a running pattern to its end and checks its shape.
    task automatic run_pat(input string tag, input logic [1:0] code,
                           input logic [3:0] g);
        int on_c = 0, busy_c = 0, rises = 0, done_c = 0, guard = 0;
        logic prev_buz = 1'b0, last_done = 1'b0;
        logic [3:0] g_done = 4'b0;
        while (busy === 1'b1 && guard < 300) begin
            if (buz_en) on_c++;
            if (buz_en && !prev_buz) rises++;
            prev_buz = buz_en;
            busy_c++;
            if (done) begin
                done_c++;
                g_done = gnt;
            end
            last_done = done;
            tick();
            guard++;
        end
        chk({tag, "_timeout"}, guard < 300, 1);
        chk({tag, "_on"}, on_c, n_beeps(code) * on_len(code));
        chk({tag, "_beeps"}, rises, n_beeps(code));
        chk({tag, "_busy"}, busy_c, busy_len(code));
        chk({tag, "_done_cnt"}, done_c, 1);
        chk({tag, "_done_last"}, last_done, 1);
        chk({tag, "_gnt_at_done"}, g_done, g);
        chk({tag, "_gnt_clr"}, gnt, 0);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0;
        pat  = 8'b0;
        stop = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_buz", buz_en, 0);
        chk("rst_done", done, 0);
        tick();
        tick();
        rst = 1'b0;

        // Rotating grants with all requesters held, codes 00.
        req = 4'b1111;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        tick();
        chk("rr_first", gnt, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            run_pat("rr", 2'b00, gnt);
            if (k == 4) req = 4'b0;
            tick();
            chk("rr_spacing", busy, (k < 4) ? 1 : 0);
        end

        // Single short beep on requester 0.
        req = 4'b0001;
        pat = 8'b0;
        exp_q.push_back(4'b0001);
        tick();
        req = 4'b0;
        chk("s1_buz", buz_en, 1);
        run_pat("s1", 2'b00, 4'b0001);

        // Three short beeps.
        req = 4'b0001;
        pat = 8'b0000_0011;
        exp_q.push_back(4'b0001);
        tick();
        req = 4'b0;
        pat = 8'b0;
        run_pat("s3", 2'b11, 4'b0001);

        // Long beep on requester 1 aborted on its 10th on-cycle.
        req = 4'b0010;
        pat = 8'b0000_0100;
        exp_q.push_back(4'b0010);
        tick();
        req = 4'b0;
        pat = 8'b0;
        repeat (9) tick();
        chk("abort_still_on", buz_en, 1);
        chk("abort_gnt_held", gnt, 4'b0010);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("abort_buz", buz_en, 0);
        chk("abort_gnt", gnt, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        req = 4'b0110;
        exp_q.push_back(4'b0100);
        tick();
        chk("after_abort_gnt", gnt, 4'b0100);
        req = 4'b0;
        run_pat("after_abort", 2'b00, 4'b0100);

        // Reset during the gap of a two-beep pattern.
        req = 4'b0001;
        pat = 8'b0000_0010;
        exp_q.push_back(4'b0001);
        tick();
        req = 4'b0;
        repeat (7) tick();
        chk("gap_buz", buz_en, 0);
        chk("gap_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("async_gnt", gnt, 0);
        chk("async_busy", busy, 0);
        chk("async_buz", buz_en, 0);
        tick();
        rst = 1'b0;
        pat = 8'b0;
        req = 4'b1111;
        exp_q.push_back(4'b0001);
        tick();
        chk("post_rst_gnt", gnt, 4'b0001);
        req = 4'b0;
        run_pat("post_rst", 2'b00, 4'b0001);

        // Stop in idle blocks a grant for that cycle only.
        req  = 4'b0010;
        stop = 1'b1;
        tick();
        chk("stop_idle_gnt", gnt, 0);
        chk("stop_idle_busy", busy, 0);
        stop = 1'b0;
        exp_q.push_back(4'b0010);
        tick();
        chk("stop_release_gnt", gnt, 4'b0010);
        req = 4'b0;
        run_pat("stop_release", 2'b00, 4'b0010);

        tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/beep_scheduler.md
BEEP_SCHEDULER -- requirements
Module: beep_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters.
REQ-002 The block SHALL have parameter SHORT_T, default 5, giving the short-beep on-time in clk_bps cycles (legal range 1..255).
REQ-003 The block SHALL have parameter LONG_T, default 20, giving the long-beep on-time in clk_bps cycles (legal range 1..255).
REQ-004 The block SHALL have parameter GAP_T, default 5, giving the silent gap between beeps of one pattern in clk_bps cycles (legal range 1..255).
REQ-005 clk_bps  input  1  tick clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req  input  NREQ  per-requester level request.
REQ-008 pat  input  2*NREQ  per-requester pattern code, pat[2i+1:2i]: 00 one short, 01 one long, 10 two short, 11 three short.
REQ-009 stop  input  1  synchronous abort of the active pattern.
REQ-010 gnt  output  NREQ  one-hot grant, held for the whole pattern.
REQ-011 busy  output  1  high while any pattern is active.
REQ-012 buz_en  output  1  buzzer enable; drives the t input of the buzzer tone generator.
REQ-013 done  output  1  one-cycle pulse on normal pattern completion.

Function
REQ-014 The FSM SHALL have states IDLE, ON, GAP, DONE; all outputs SHALL be registered.
REQ-015 In IDLE with any req bit high, the next edge SHALL go to ON, set gnt to the round-robin winner, latch its pat, and load the tick counter.
REQ-016 Arbitration SHALL be round-robin: search starts at index (last granted + 1) mod NREQ; after reset, last granted = NREQ-1, so index 0 wins first.
REQ-017 ON SHALL last exactly SHORT_T (codes 00, 10, 11) or LONG_T (code 01) cycles with buz_en=1.
REQ-018 On ON expiry with beeps remaining, the FSM SHALL go to GAP for exactly GAP_T cycles with buz_en=0, then back to ON.
REQ-019 On ON expiry with no beeps remaining, the FSM SHALL go to DONE for one cycle with done=1, buz_en=0, gnt still asserted, then to IDLE with gnt cleared.
REQ-020 busy SHALL be 1 in ON, GAP and DONE, and 0 in IDLE.
REQ-021 Minimum spacing SHALL be one IDLE cycle between DONE and the next ON.
REQ-022 The latched pattern SHALL be unaffected by pat or req changes after grant; deasserting req after grant SHALL NOT abort.
REQ-023 stop=1 in ON, GAP or DONE SHALL force IDLE on the next edge with gnt=0, buz_en=0, done=0; the aborted requester SHALL count as last granted.
REQ-024 stop=1 in IDLE SHALL block a grant in that cycle; stop SHALL take priority over a new request.
REQ-025 The tick counter SHALL be 8 bits, count down to 1, and never wrap; the beep counter SHALL be 2 bits.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, gnt=0, busy=0, buz_en=0, done=0, counters=0, last granted=NREQ-1, including mid-pattern.
REQ-027 After rst falls, the first grant SHALL occur on the first clk_bps edge that sees a request.

Structure
REQ-028 Package beep_pkg SHALL hold the state enum, the pattern code enum, and the default SHORT_T/LONG_T/GAP_T constants.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, last granted; output one-hot winner); the timing FSM stays in beep_scheduler.

Verification
REQ-030 req=0001, pat code 00 -> gnt=0001, buz_en high exactly 5 cycles, done pulses 1 cycle later, gnt clears next cycle.
REQ-031 req0 code 11 -> buz_en pattern 5 on, 5 off, 5 on, 5 off, 5 on; single done; busy high for 26 cycles.
REQ-032 req=1111 held constantly, all codes 00 -> grants go 0001, 0010, 0100, 1000, 0001, with one IDLE cycle between.
REQ-033 req1 code 01, stop asserted on the 10th ON cycle -> next cycle buz_en=0, gnt=0, no done; next grant goes to index 2 if requesting.
REQ-034 rst pulsed during GAP of a code 10 pattern -> outputs go 0 asynchronously; the first post-reset grant goes to index 0.
REQ-035 req and stop both high in IDLE -> no grant that cycle; grant on the following edge once stop=0.
